// File: rtl/divider_16.sv
// divider_16 -- sequential unsigned 32/16 divider, radix-2 restoring.
//
// One quotient bit is produced per clock. It sits beside the 16x16 multiplier
// behind the same start/done handshake, so a controller can scale a product
// back down.
//
// Ports:
//   clk          in   1   rising-edge clock
//   res_n        in   1   asynchronous active-low reset
//   start        in   1   request a division (accepted in IDLE or DONE)
//   dividend     in  32   unsigned dividend, latched on the accepting edge
//   divisor      in  16   unsigned divisor, latched on the accepting edge
//   busy         out  1   division in progress
//   done         out  1   result valid; held until the next accepted start
//   quotient     out 16   unsigned quotient
//   remainder    out 16   unsigned remainder
//   div_by_zero  out  1   divisor was zero
//   overflow     out  1   true quotient does not fit in 16 bits
//
// Timing from the accepting edge E:
//   normal : busy after E .. E+15, done/result after E+16
//   errors : done/result after E+1
module divider_16 (
    input  logic        clk,
    input  logic        res_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;

    // Partial remainder R. The architectural R is 17 bits, but R < divisor
    // holds after every step, so its top bit is always zero and not stored.
    logic [15:0] r_rem,   w_rem_nxt;
    logic [15:0] r_q,     w_q_nxt;     // low shift register / quotient bits
    logic [3:0]  r_cnt,   w_cnt_nxt;   // restoring step counter
    logic [15:0] r_dvs,   w_dvs_nxt;   // latched divisor

    // Error detected on the accepting edge; reported one edge later so the
    // error paths keep a fixed one-cycle latency with busy high in between.
    logic        r_err_dz, w_err_dz_nxt;
    logic        r_err_ov, w_err_ov_nxt;

    logic        r_busy,  w_busy_nxt;
    logic        r_done,  w_done_nxt;
    logic        r_dz,    w_dz_nxt;
    logic        r_ov,    w_ov_nxt;
    logic [15:0] r_quot,  w_quot_nxt;
    logic [15:0] r_remo,  w_remo_nxt;

    // One restoring step: shift the next dividend bit into R, try subtract.
    logic [16:0] w_t;
    logic        w_ge;
    logic [15:0] w_diff;
    logic [15:0] w_rem_step;
    logic [15:0] w_q_step;

    assign w_t        = {r_rem, r_q[15]};
    assign w_ge       = (w_t >= {1'b0, r_dvs});
    // When w_ge holds the true difference is below the divisor, so the
    // 16-bit subtraction cannot lose information.
    assign w_diff     = w_t[15:0] - r_dvs;
    assign w_rem_step = w_ge ? w_diff : w_t[15:0];
    assign w_q_step   = {r_q[14:0], w_ge};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state  <= IDLE;
            r_rem    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_dvs    <= '0;
            r_err_dz <= 1'b0;
            r_err_ov <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_ov     <= 1'b0;
            r_quot   <= '0;
            r_remo   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rem    <= w_rem_nxt;
            r_q      <= w_q_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dvs    <= w_dvs_nxt;
            r_err_dz <= w_err_dz_nxt;
            r_err_ov <= w_err_ov_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_dz     <= w_dz_nxt;
            r_ov     <= w_ov_nxt;
            r_quot   <= w_quot_nxt;
            r_remo   <= w_remo_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;
        w_q_nxt      = r_q;
        w_cnt_nxt    = r_cnt;
        w_dvs_nxt    = r_dvs;
        w_err_dz_nxt = r_err_dz;
        w_err_ov_nxt = r_err_ov;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;
        w_dz_nxt     = r_dz;
        w_ov_nxt     = r_ov;
        w_quot_nxt   = r_quot;
        w_remo_nxt   = r_remo;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    // Latch operands; the result outputs keep the previous
                    // value until this run writes its own.
                    w_dvs_nxt    = divisor;
                    w_rem_nxt    = dividend[31:16];
                    w_q_nxt      = dividend[15:0];
                    w_cnt_nxt    = 4'd0;
                    w_err_dz_nxt = (divisor == 16'd0);
                    w_err_ov_nxt = (divisor != 16'd0) &&
                                   (dividend[31:16] >= divisor);
                    w_busy_nxt   = 1'b1;
                    w_done_nxt   = 1'b0;
                    w_dz_nxt     = 1'b0;
                    w_ov_nxt     = 1'b0;
                    w_state_nxt  = CALC;
                end
            end

            CALC: begin
                if (r_err_dz || r_err_ov) begin
                    // Error result: saturated quotient. For divide-by-zero
                    // the low dividend half (still sitting in Q) is returned.
                    w_quot_nxt   = 16'hFFFF;
                    w_remo_nxt   = r_err_dz ? r_q : 16'h0000;
                    w_dz_nxt     = r_err_dz;
                    w_ov_nxt     = r_err_ov;
                    w_err_dz_nxt = 1'b0;
                    w_err_ov_nxt = 1'b0;
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = DONE;
                end else begin
                    w_rem_nxt = w_rem_step;
                    w_q_nxt   = w_q_step;
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        w_quot_nxt  = w_q_step;
                        w_remo_nxt  = w_rem_step;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dz;
    assign overflow    = r_ov;

endmodule

// File: tb/tb_divider_16.sv
// Bench for divider_16: scoreboard of expected results pushed at each start,
// popped and compared when done rises.
module tb_divider_16;

    logic        clk = 1'b0;
    logic        res_n;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    divider_16 dut (
        .clk        (clk),
        .res_n      (res_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
    } exp_t;

    exp_t sbq[$];

    // Last completed result, which the outputs must hold while busy.
    logic [31:0] prev_qr = 32'h0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain integer division plus the error rules.
    task automatic push_exp(input logic [31:0] dvd, input logic [15:0] dvs);
        exp_t e;
        e.dvd = dvd;
        e.dvs = dvs;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        if (dvs == 16'd0) begin
            e.dz = 1'b1;
            e.q  = 16'hFFFF;
            e.r  = dvd[15:0];
        end else if (dvd[31:16] >= dvs) begin
            e.ov = 1'b1;
            e.q  = 16'hFFFF;
            e.r  = 16'h0000;
        end else begin
            e.q = 16'(dvd / {16'h0, dvs});
            e.r = 16'(dvd % {16'h0, dvs});
        end
        sbq.push_back(e);
    endtask

    // Drive one start pulse; returns just after the accepting edge.
    task automatic launch(input logic [31:0] dvd, input logic [15:0] dvs);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        push_exp(dvd, dvs);
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        res_n    = 1'b0;
        start    = 1'b0;
        dividend = 32'h0;
        divisor  = 16'h0;
        #12;
        total++;
        if ({busy, done, div_by_zero, overflow, quotient, remainder} !== 36'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {busy, done, div_by_zero, overflow, quotient, remainder});
        end
        tick();
        res_n = 1'b1;
        tick();
        tick();
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_release: busy/done got %b want 00", {busy, done});
        end
    endtask

    task automatic test_normal;
        logic [31:0] tv_dvd [5];
        logic [15:0] tv_dvs [5];
        tv_dvd = '{32'd100, 32'hFFFE0001, 32'd0, 32'h0000FFFF, 32'h7FFF8000};
        tv_dvs = '{16'd7,   16'hFFFF,     16'd5, 16'd1,        16'h8000};
        for (int k = 0; k < 5; k++) begin
            int   n;
            logic busy_ok;
            logic hold_ok;
            exp_t e;
            launch(tv_dvd[k], tv_dvs[k]);
            n = 0;
            busy_ok = 1'b1;
            hold_ok = 1'b1;
            while (done !== 1'b1 && n < 40) begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if ({quotient, remainder} !== prev_qr) hold_ok = 1'b0;
                tick();
                n++;
            end
            e = sbq.pop_front();
            total++;
            if (n != 16) begin
                bad++;
                $display("FAIL normal_latency[%0d]: got %0d want 16", k, n);
            end
            total++;
            if (!busy_ok || busy !== 1'b0) begin
                bad++;
                $display("FAIL normal_busy[%0d]: during_ok %b final %b want 1/0", k, busy_ok, busy);
            end
            total++;
            if (!hold_ok) begin
                bad++;
                $display("FAIL normal_hold[%0d]: result changed while busy, want %h", k, prev_qr);
            end
            total++;
            if ({quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dz, e.ov}) begin
                bad++;
                $display("FAIL normal_result[%0d]: got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=%b ov=%b",
                         k, quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dz, e.ov);
            end
            prev_qr = {e.q, e.r};
            tick();
        end
    endtask

    task automatic test_errors;
        logic [31:0] tv_dvd [4];
        logic [15:0] tv_dvs [4];
        tv_dvd = '{32'h00010000, 32'h1234ABCD, 32'hFFFF0000, 32'h00000000};
        tv_dvs = '{16'd1,        16'd0,        16'hFFFF,     16'd0};
        for (int k = 0; k < 4; k++) begin
            int   n;
            exp_t e;
            launch(tv_dvd[k], tv_dvs[k]);
            total++;
            if ({busy, done} !== 2'b10 || {quotient, remainder} !== prev_qr) begin
                bad++;
                $display("FAIL err_accept[%0d]: busy/done %b%b qr %h want 10 %h",
                         k, busy, done, {quotient, remainder}, prev_qr);
            end
            n = 0;
            while (done !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            e = sbq.pop_front();
            total++;
            if (n != 1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL err_latency[%0d]: got %0d busy %b want 1 busy 0", k, n, busy);
            end
            total++;
            if ({quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dz, e.ov}) begin
                bad++;
                $display("FAIL err_result[%0d]: got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=%b ov=%b",
                         k, quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dz, e.ov);
            end
            prev_qr = {e.q, e.r};
        end
    endtask

    task automatic test_ignore_start;
        int   n;
        exp_t e;
        launch(32'd1000000, 16'd1000);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            // Second start pulse lands on edge E+5, mid-run, with other operands.
            if (n == 4) begin
                start    = 1'b1;
                dividend = 32'd7;
                divisor  = 16'd3;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        e = sbq.pop_front();
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL ignore_latency: got %0d want 16", n);
        end
        total++;
        if ({quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dz, e.ov}) begin
            bad++;
            $display("FAIL ignore_result: got q=%0d r=%0d want q=%0d r=%0d", quotient, remainder, e.q, e.r);
        end
        prev_qr = {e.q, e.r};
        for (int k = 0; k < 3; k++) tick();
        total++;
        if ({busy, done, quotient, remainder} !== {2'b01, prev_qr}) begin
            bad++;
            $display("FAIL done_hold: got busy %b done %b qr %h want 0 1 %h", busy, done, {quotient, remainder}, prev_qr);
        end
    endtask

    task automatic test_reset_mid;
        int   n;
        exp_t e;
        launch(32'd1000000, 16'd1000);
        for (int k = 0; k < 7; k++) tick();
        res_n = 1'b0;
        #1;
        e = sbq.pop_front();
        total++;
        if ({busy, done, div_by_zero, overflow, quotient, remainder} !== 36'h0) begin
            bad++;
            $display("FAIL reset_mid: got %h want 0",
                     {busy, done, div_by_zero, overflow, quotient, remainder});
        end
        prev_qr = 32'h0;
        tick();
        tick();
        // Release and request in the same cycle: the first edge must accept.
        res_n    = 1'b1;
        dividend = 32'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        push_exp(32'd100, 16'd7);
        tick();
        start = 1'b0;
        total++;
        if ({busy, done} !== 2'b10) begin
            bad++;
            $display("FAIL first_edge_start: busy/done got %b%b want 10", busy, done);
        end
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        e = sbq.pop_front();
        total++;
        if (n != 16 || {quotient, remainder} !== {e.q, e.r}) begin
            bad++;
            $display("FAIL after_reset_run: lat %0d q=%0d r=%0d want 16 q=%0d r=%0d", n, quotient, remainder, e.q, e.r);
        end
        prev_qr = {e.q, e.r};
    endtask

    task automatic test_held_start;
        int   n;
        exp_t e;
        dividend = 32'h00123456;
        divisor  = 16'h0F00;
        start    = 1'b1;
        for (int run = 0; run < 2; run++) begin
            push_exp(dividend, divisor);
            tick();
            total++;
            if ({busy, done} !== 2'b10) begin
                bad++;
                $display("FAIL held_restart[%0d]: busy/done got %b%b want 10", run, busy, done);
            end
            n = 0;
            while (done !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            e = sbq.pop_front();
            total++;
            if (n != 16 || {quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dz, e.ov}) begin
                bad++;
                $display("FAIL held_result[%0d]: lat %0d q=%h r=%h want 16 q=%h r=%h", run, n, quotient, remainder, e.q, e.r);
            end
        end
        start   = 1'b0;
        prev_qr = {e.q, e.r};
        tick();
    endtask

    task automatic test_back_to_back;
        int          n;
        exp_t        e;
        logic [15:0] dvs;
        logic [15:0] hi;
        longint unsigned recon;
        dvs      = 16'($urandom_range(1, 65535));
        hi       = 16'($urandom_range(0, int'(dvs) - 1));
        dividend = {hi, 16'($urandom)};
        divisor  = dvs;
        start    = 1'b1;
        push_exp(dividend, divisor);
        tick();
        start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            n = 0;
            while (done !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            e = sbq.pop_front();
            total++;
            if (n != 16) begin
                bad++;
                $display("FAIL b2b_latency[%0d]: got %0d want 16", i, n);
                break;
            end
            recon = longint'(quotient) * longint'(e.dvs) + longint'(remainder);
            total++;
            if (recon != longint'(e.dvd) || remainder >= e.dvs) begin
                bad++;
                $display("FAIL b2b_invariant[%0d]: q*d+r=%0d r=%0d want %0d r<%0d", i, recon, remainder, e.dvd, e.dvs);
            end
            total++;
            if ({quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dz, e.ov}) begin
                bad++;
                $display("FAIL b2b_result[%0d]: got q=%h r=%h dz=%b ov=%b want q=%h r=%h 0 0",
                         i, quotient, remainder, div_by_zero, overflow, e.q, e.r);
            end
            if (i < 999) begin
                dvs      = 16'($urandom_range(1, 65535));
                hi       = 16'($urandom_range(0, int'(dvs) - 1));
                dividend = {hi, 16'($urandom)};
                divisor  = dvs;
                start    = 1'b1;
                push_exp(dividend, divisor);
                tick();
                start = 1'b0;
                total++;
                if ({busy, done} !== 2'b10) begin
                    bad++;
                    $display("FAIL b2b_restart[%0d]: busy/done got %b%b want 10", i, busy, done);
                end
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_normal();
        test_errors();
        test_ignore_start();
        test_reset_mid();
        test_held_start();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
